// File: rtl/logistic_batch_predict_if.sv
// Handshake bundle for logistic_batch_predict: sample batch in, Theta in, batch predictions out.
interface logistic_batch_predict_if #(
    parameter int unsigned N         = 1,
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned BATCH     = 4
);
    localparam int unsigned PW = $bits(N_CLASSES);

    logic [BATCH-1:0][N-1:0][31:0]     input_X;
    logic                              input_X_stb;
    logic                              input_X_ack;
    logic [N-1:0][N_CLASSES-1:0][31:0] input_Theta;
    logic                              input_Theta_stb;
    logic                              input_Theta_ack;
    logic [BATCH-1:0][PW-1:0]          output_predictions;
    logic                              output_predictions_stb;
    logic                              output_predictions_ack;
    logic                              busy;

    modport master (
        output input_X, input_X_stb, input_Theta, input_Theta_stb, output_predictions_ack,
        input  input_X_ack, input_Theta_ack, output_predictions, output_predictions_stb, busy
    );

    modport slave (
        input  input_X, input_X_stb, input_Theta, input_Theta_stb, output_predictions_ack,
        output input_X_ack, input_Theta_ack, output_predictions, output_predictions_stb, busy
    );
endinterface

// File: rtl/logistic_batch_predict.sv
// Single-sample logistic predictor (argmax of Theta^T x, IEEE-754 single, truncating) and a
// batch scheduler that streams BATCH samples through one predictor instance.
module logistic_predict #(
    parameter int unsigned N                       = 1,
    parameter int unsigned N_CLASSES               = 10,
    parameter int unsigned MATMUL_N_INNER_PRODUCTS = 1,
    parameter int unsigned MATMUL_IP_N_THRESH      = 1,
    parameter int unsigned PW                      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0][31:0]                input_X,
    input  logic                              input_X_stb,
    output logic                              input_X_ack,
    input  logic [N-1:0][N_CLASSES-1:0][31:0] input_Theta,
    input  logic                              input_Theta_stb,
    output logic                              input_Theta_ack,
    output logic [PW-1:0]                     output_prediction,
    output logic                              output_prediction_stb,
    input  logic                              output_prediction_ack
);
    // Features consumed per cycle: all at once for small N, else MATMUL_N_INNER_PRODUCTS.
    localparam int unsigned K_EFF = (N <= MATMUL_IP_N_THRESH)           ? N :
                                    (MATMUL_N_INNER_PRODUCTS >= N)      ? N :
                                    (MATMUL_N_INNER_PRODUCTS == 0)      ? 1 : MATMUL_N_INNER_PRODUCTS;
    localparam logic [1:0] C_X = 2'd0, C_TH = 2'd1, C_RUN = 2'd2, C_OUT = 2'd3;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return '0;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, p[47]};
        m = p[47] ? p[46:24] : p[45:23];
        if (e <= 10'd127) return '0;
        if (e >= 10'd381) return {a[31] ^ b[31], 8'hFE, 23'h7FFFFF};
        return {a[31] ^ b[31], 8'(e - 10'd127), m};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  d;
        logic [26:0] mx, my, s;
        logic [9:0]  e;
        logic [4:0]  lz;
        logic        found;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = x[30:23] - y[30:23];
        mx = {2'b01, x[22:0], 2'b00};
        my = (d > 8'd26) ? '0 : ({2'b01, y[22:0], 2'b00} >> d);
        e  = {2'b00, x[30:23]};
        if (x[31] == y[31]) begin
            s = mx + my;
            if (!s[26]) return {x[31], x[30:23], s[24:2]};
            if (e >= 10'd254) return {x[31], 8'hFE, 23'h7FFFFF};
            return {x[31], 8'(e + 10'd1), s[25:3]};
        end
        s = mx - my;
        if (s == '0) return '0;
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 26; i++) begin
            if (!found && s[25 - i]) begin
                found = 1'b1;
                lz    = 5'(i);
            end
        end
        if (e <= {5'd0, lz}) return '0;
        s = s << lz;
        return {x[31], 8'(e - {5'd0, lz}), s[24:2]};
    endfunction

    // Maps a float to an unsigned key with the same ordering (no -0 is ever produced).
    function automatic logic [31:0] fkey(input logic [31:0] v);
        return v[31] ? ~v : {1'b1, v[30:0]};
    endfunction

    logic [1:0]                        state_q;
    logic                              x_ack_q, th_ack_q, pred_stb_q;
    logic [PW-1:0]                     pred_q;
    logic [N-1:0][31:0]                x_q;
    logic [N-1:0][N_CLASSES-1:0][31:0] th_q;
    logic [N_CLASSES-1:0][31:0]        acc_q, acc_d;
    logic [31:0]                       feat_q;
    logic                              last;
    logic [PW-1:0]                     best;
    logic [31:0]                       bestv;

    always_comb begin
        acc_d = acc_q;
        for (int unsigned c = 0; c < N_CLASSES; c++) begin
            for (int unsigned n = 0; n < N; n++) begin
                if (n >= feat_q && n < feat_q + K_EFF)
                    acc_d[c] = fadd(acc_d[c], fmul(x_q[n], th_q[n][c]));
            end
        end
        last  = (feat_q + K_EFF >= N);
        best  = '0;
        bestv = acc_d[0];
        for (int unsigned c = 1; c < N_CLASSES; c++) begin
            if (fkey(acc_d[c]) > fkey(bestv)) begin
                bestv = acc_d[c];
                best  = PW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= C_X;
            x_ack_q    <= 1'b0;
            th_ack_q   <= 1'b0;
            pred_stb_q <= 1'b0;
            pred_q     <= '0;
            x_q        <= '0;
            th_q       <= '0;
            acc_q      <= '0;
            feat_q     <= '0;
        end else begin
            case (state_q)
                C_X: begin
                    if (input_X_stb && x_ack_q) begin
                        x_q      <= input_X;
                        x_ack_q  <= 1'b0;
                        th_ack_q <= 1'b1;
                        state_q  <= C_TH;
                    end else begin
                        x_ack_q <= 1'b1;
                    end
                end
                C_TH: begin
                    if (input_Theta_stb && th_ack_q) begin
                        th_q     <= input_Theta;
                        th_ack_q <= 1'b0;
                        acc_q    <= '0;
                        feat_q   <= '0;
                        state_q  <= C_RUN;
                    end
                end
                C_RUN: begin
                    acc_q  <= acc_d;
                    feat_q <= feat_q + K_EFF;
                    if (last) begin
                        pred_q     <= best;
                        pred_stb_q <= 1'b1;
                        state_q    <= C_OUT;
                    end
                end
                default: begin
                    if (output_prediction_ack && pred_stb_q) begin
                        pred_stb_q <= 1'b0;
                        x_ack_q    <= 1'b1;
                        state_q    <= C_X;
                    end
                end
            endcase
        end
    end

    assign input_X_ack           = x_ack_q;
    assign input_Theta_ack       = th_ack_q;
    assign output_prediction     = pred_q;
    assign output_prediction_stb = pred_stb_q;
endmodule

module logistic_batch_predict #(
    parameter int unsigned N                       = 1,
    parameter int unsigned N_CLASSES               = 10,
    parameter int unsigned BATCH                   = 4,
    parameter int unsigned MATMUL_N_INNER_PRODUCTS = 1,
    parameter int unsigned MATMUL_IP_N_THRESH      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    logistic_batch_predict_if.slave bus
);
    localparam int unsigned PW = $bits(N_CLASSES);
    localparam int unsigned IW = $clog2(BATCH) + 1;
    localparam logic [2:0] IDLE = 3'd0, FEED_X = 3'd1, FEED_TH = 3'd2, GET_PRED = 3'd3, PUT_OUT = 3'd4;

    logic [2:0]                        state_q;
    logic [IW-1:0]                     idx_q;
    logic                              theta_valid_q, x_ack_q, th_ack_q, out_stb_q;
    logic                              c_x_stb_q, c_th_stb_q, c_pred_ack_q;
    logic [BATCH-1:0][N-1:0][31:0]     batch_q;
    logic [N-1:0][N_CLASSES-1:0][31:0] theta_q;
    logic [BATCH-1:0][PW-1:0]          preds_q, out_q;
    logic [N-1:0][31:0]                c_x;
    logic                              c_x_ack, c_th_ack, c_pred_stb;
    logic [PW-1:0]                     c_pred;

    always_comb begin
        c_x = '0;
        for (int unsigned i = 0; i < BATCH; i++) begin
            if (idx_q == IW'(i)) c_x = batch_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            theta_valid_q <= 1'b0;
            x_ack_q       <= 1'b0;
            th_ack_q      <= 1'b0;
            out_stb_q     <= 1'b0;
            c_x_stb_q     <= 1'b0;
            c_th_stb_q    <= 1'b0;
            c_pred_ack_q  <= 1'b0;
            batch_q       <= '0;
            theta_q       <= '0;
            preds_q       <= '0;
            out_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    th_ack_q <= 1'b1;
                    x_ack_q  <= theta_valid_q;
                    if (bus.input_Theta_stb && th_ack_q) begin
                        theta_q       <= bus.input_Theta;
                        theta_valid_q <= 1'b1;
                    end
                    if (bus.input_X_stb && x_ack_q) begin
                        batch_q   <= bus.input_X;
                        idx_q     <= '0;
                        x_ack_q   <= 1'b0;
                        th_ack_q  <= 1'b0;
                        c_x_stb_q <= 1'b1;
                        state_q   <= FEED_X;
                    end
                end
                FEED_X: begin
                    if (c_x_stb_q && c_x_ack) begin
                        c_x_stb_q  <= 1'b0;
                        c_th_stb_q <= 1'b1;
                        state_q    <= FEED_TH;
                    end
                end
                FEED_TH: begin
                    if (c_th_stb_q && c_th_ack) begin
                        c_th_stb_q   <= 1'b0;
                        c_pred_ack_q <= 1'b1;
                        state_q      <= GET_PRED;
                    end
                end
                GET_PRED: begin
                    if (c_pred_stb && c_pred_ack_q) begin
                        for (int unsigned i = 0; i < BATCH; i++) begin
                            if (idx_q == IW'(i)) preds_q[i] <= c_pred;
                        end
                        c_pred_ack_q <= 1'b0;
                        if (idx_q == IW'(BATCH - 1)) begin
                            state_q <= PUT_OUT;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            c_x_stb_q <= 1'b1;
                            state_q   <= FEED_X;
                        end
                    end
                end
                PUT_OUT: begin
                    // First cycle publishes the collected batch; stb then holds until taken.
                    if (!out_stb_q) begin
                        out_q     <= preds_q;
                        out_stb_q <= 1'b1;
                    end else if (bus.output_predictions_ack) begin
                        out_stb_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logistic_predict #(
        .N                       (N),
        .N_CLASSES               (N_CLASSES),
        .MATMUL_N_INNER_PRODUCTS (MATMUL_N_INNER_PRODUCTS),
        .MATMUL_IP_N_THRESH      (MATMUL_IP_N_THRESH),
        .PW                      (PW)
    ) u_pred (
        .clk                   (clk),
        .rst                   (rst),
        .input_X               (c_x),
        .input_X_stb           (c_x_stb_q),
        .input_X_ack           (c_x_ack),
        .input_Theta           (theta_q),
        .input_Theta_stb       (c_th_stb_q),
        .input_Theta_ack       (c_th_ack),
        .output_prediction     (c_pred),
        .output_prediction_stb (c_pred_stb),
        .output_prediction_ack (c_pred_ack_q)
    );

    assign bus.input_X_ack            = x_ack_q;
    assign bus.input_Theta_ack        = th_ack_q;
    assign bus.output_predictions     = out_q;
    assign bus.output_predictions_stb = out_stb_q;
    assign bus.busy                   = (state_q != IDLE);
endmodule
